// File: rtl/axi_lite_arbiter.sv
// Two-requester round-robin arbiter driving a single AXI-lite master port.
// Each grant runs one complete read or write before arbitration resumes.
module axi_lite_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic                A_clk,
   input  logic                A_reset,
   input  logic [1:0]          req,
   input  logic [1:0]          wr,
   input  logic [2*ADDR_W-1:0] addr,
   input  logic [2*DATA_W-1:0] wdata,
   output logic [1:0]          done,
   output logic [DATA_W-1:0]   rdata,
   output logic                err,
   output logic                busy,
   output logic [ADDR_W-1:0]   AR_addr,
   output logic                AR_valid,
   input  logic                AR_ready,
   input  logic [DATA_W-1:0]   R_data,
   input  logic                R_resp,
   input  logic                R_valid,
   output logic                R_ready,
   output logic [ADDR_W-1:0]   AW_addr,
   output logic                AW_valid,
   input  logic                AW_ready,
   output logic [DATA_W-1:0]   W_data,
   output logic                W_valid,
   input  logic                W_ready,
   input  logic                B_resp,
   input  logic                B_valid,
   output logic                B_ready
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE} state_t;

   state_t              state_reg, state_next;
   logic                last_grant_reg, last_grant_next;
   logic                grant_reg, grant_next;
   logic [1:0]          done_next;
   logic [DATA_W-1:0]   rdata_next;
   logic                err_next, busy_next;
   logic [ADDR_W-1:0]   ar_addr_next, aw_addr_next;
   logic [DATA_W-1:0]   w_data_next;
   logic                ar_valid_next, r_ready_next, aw_valid_next, w_valid_next, b_ready_next;
   logic                win;

   logic [ADDR_W-1:0]   addr_arr  [2];
   logic [DATA_W-1:0]   wdata_arr [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // On a tie the requester that did not win last time takes the grant.
   assign win = (req == 2'b11) ? ~last_grant_reg : req[1];

   always_ff @(posedge A_clk or negedge A_reset) begin
      if (!A_reset) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         grant_reg      <= 1'b0;
         done           <= '0;
         rdata          <= '0;
         err            <= 1'b0;
         busy           <= 1'b0;
         AR_addr        <= '0;
         AR_valid       <= 1'b0;
         R_ready        <= 1'b0;
         AW_addr        <= '0;
         AW_valid       <= 1'b0;
         W_data         <= '0;
         W_valid        <= 1'b0;
         B_ready        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         grant_reg      <= grant_next;
         done           <= done_next;
         rdata          <= rdata_next;
         err            <= err_next;
         busy           <= busy_next;
         AR_addr        <= ar_addr_next;
         AR_valid       <= ar_valid_next;
         R_ready        <= r_ready_next;
         AW_addr        <= aw_addr_next;
         AW_valid       <= aw_valid_next;
         W_data         <= w_data_next;
         W_valid        <= w_valid_next;
         B_ready        <= b_ready_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      grant_next      = grant_reg;
      done_next       = '0;
      rdata_next      = rdata;
      err_next        = err;
      ar_addr_next    = AR_addr;
      ar_valid_next   = AR_valid;
      r_ready_next    = R_ready;
      aw_addr_next    = AW_addr;
      aw_valid_next   = AW_valid;
      w_data_next     = W_data;
      w_valid_next    = W_valid;
      b_ready_next    = B_ready;

      case (state_reg)
         IDLE: begin
            if (req != 2'b00) begin
               grant_next      = win;
               last_grant_next = win;
               if (wr[win]) begin
                  aw_addr_next  = addr_arr[win];
                  w_data_next   = wdata_arr[win];
                  aw_valid_next = 1'b1;
                  w_valid_next  = 1'b1;
                  state_next    = WR_ADDR;
               end else begin
                  ar_addr_next  = addr_arr[win];
                  ar_valid_next = 1'b1;
                  state_next    = RD_ADDR;
               end
            end
         end
         RD_ADDR: begin
            if (AR_ready) begin
               ar_valid_next = 1'b0;
               r_ready_next  = 1'b1;
               state_next    = RD_DATA;
            end
         end
         RD_DATA: begin
            if (R_valid) begin
               r_ready_next          = 1'b0;
               rdata_next            = R_data;
               err_next              = R_resp;
               done_next[grant_reg]  = 1'b1;
               state_next            = DONE;
            end
         end
         WR_ADDR: begin
            // Each channel retires on its own ready; leave once neither is still pending.
            aw_valid_next = AW_valid & ~AW_ready;
            w_valid_next  = W_valid & ~W_ready;
            if (!aw_valid_next && !w_valid_next) begin
               b_ready_next = 1'b1;
               state_next   = WR_RESP;
            end
         end
         WR_RESP: begin
            if (B_valid) begin
               b_ready_next          = 1'b0;
               err_next              = B_resp;
               done_next[grant_reg]  = 1'b1;
               state_next            = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning AXI-lite address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning AXI-lite data width.
REQ-003 Port A_clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port A_reset  in  1  asynchronous, active-low reset.
REQ-005 Port req  in  2  per-requester transaction request; bit i = requester i.
REQ-006 Port wr  in  2  per-requester direction; 1 = write, 0 = read.
REQ-007 Port addr  in  2*ADDR_W  {addr1,addr0} request addresses.
REQ-008 Port wdata  in  2*DATA_W  {wdata1,wdata0} write data.
REQ-009 Port done  out  2  one-cycle completion pulse to the granted requester.
REQ-010 Port rdata  out  DATA_W  read data; valid while done is high.
REQ-011 Port err  out  1  captured R_resp/B_resp; valid while done is high.
REQ-012 Port busy  out  1  high whenever the FSM is not IDLE.
REQ-013 Ports AR_addr out ADDR_W, AR_valid out 1, AR_ready in 1: read address channel.
REQ-014 Ports R_data in DATA_W, R_resp in 1, R_valid in 1, R_ready out 1: read data channel.
REQ-015 Ports AW_addr out ADDR_W, AW_valid out 1, AW_ready in 1: write address channel.
REQ-016 Ports W_data out DATA_W, W_valid out 1, W_ready in 1: write data channel.
REQ-017 Ports B_resp in 1, B_valid in 1, B_ready out 1: write response channel.

Function
REQ-018 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE; all outputs registered.
REQ-019 IDLE SHALL grant a request when any req bit is high: a single requester wins directly; when both are high, the requester not equal to last_grant wins (round robin).
REQ-020 On grant, the block SHALL latch the winner's wr, addr and wdata, update last_grant, and move to RD_ADDR (wr=0) or WR_ADDR (wr=1).
REQ-021 RD_ADDR SHALL hold AR_valid=1 with AR_addr=latched address until AR_ready is sampled high, then move to RD_DATA.
REQ-022 RD_DATA SHALL hold R_ready=1; on R_valid it SHALL capture R_data into rdata and R_resp into err, then move to DONE.
REQ-023 WR_ADDR SHALL raise AW_valid and W_valid together and clear each independently on its own ready; it SHALL move to WR_RESP once both handshakes are complete, whether they occur in the same or different cycles.
REQ-024 WR_RESP SHALL hold B_ready=1; on B_valid it SHALL capture B_resp into err, then move to DONE.
REQ-025 DONE SHALL pulse done[granted]=1 for exactly one cycle, then return to IDLE; no arbitration occurs in DONE.
REQ-026 Once asserted, a valid SHALL NOT drop before its ready is sampled; address and data SHALL remain stable while valid is high.
REQ-027 Minimum latency with always-ready slave, measured from req sampled in IDLE: AR_valid/AW_valid at +1, done at +3.
REQ-028 The block SHALL ignore req deassertion or change after grant; the latched transaction completes.
REQ-029 Requesters SHALL hold req high until done; a requester that holds req after done is re-arbitrated in the following IDLE cycle.
REQ-030 rdata SHALL retain its last captured value; on writes, rdata is unchanged.

Reset
REQ-031 A_reset low SHALL immediately force state=IDLE and last_grant=1 (requester 0 wins the first tie).
REQ-032 A_reset low SHALL immediately force all outputs (valids, readys, done, busy, err, rdata, AR_addr, AW_addr, W_data) to 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no done pulse; the first request after reset release is arbitrated fresh.

Verification
REQ-034 Single read, req=01, wr=00, addr0=0x12; slave AR_ready=1, R_data=0xA5, R_resp=0 -> AR_addr=0x12, done=01 at +3, rdata=0xA5, err=0.
REQ-035 Single write, req=10, wr=10, addr1=0x34, wdata1=0x5C; AW_ready at +1, W_ready delayed to +4 -> AW_valid drops at +2, W_valid holds until +4, then B_ready, then done=10.
REQ-036 Tie case: req=11 held continuously from reset -> grants alternate 0,1,0,1 across four transactions.
REQ-037 Read with R_resp=1 -> done pulse with err=1; a following write with B_resp=0 -> err=0.
REQ-038 A_reset asserted while in WR_ADDR with AW_valid=1 -> all outputs 0 immediately, no done pulse; after release, req=10 wins.
REQ-039 Stall case: AR_ready held low 10 cycles -> AR_valid and AR_addr stable throughout; busy=1.
